timer_unit_counter: RTL and testbench

Timer-unit counter stage directly downstream of the timer prescaler. It consumes the prescaler's single-cycle tick enable and advances a WIDTH-bit count. On a match against a compare value it emits a registered one-cycle match pulse and either auto-reloads to zero (continuous mode) or halts (one-shot mode). Its outputs feed the timer register file and the interrupt/event logic.

---
 rtl/timer_unit_counter_if.sv | 26 ++
 rtl/timer_unit_counter.sv | 117 +++++++++++
 tb/tb_timer_unit_counter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_unit_counter_if.sv
// timer_unit_counter_if: control, compare and status bundle between the timer
// control logic (master) and the timer-unit counter stage (slave).
interface timer_unit_counter_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             stop_i;
  logic             clear_i;
  logic             oneshot_i;
  logic             tick_i;
  logic [WIDTH-1:0] cmp_i;
  logic [WIDTH-1:0] count_o;
  logic             running_o;
  logic             match_o;
  logic             done_o;

  modport master (
    output start_i, stop_i, clear_i, oneshot_i, tick_i, cmp_i,
    input  count_o, running_o, match_o, done_o
  );

  modport slave (
    input  start_i, stop_i, clear_i, oneshot_i, tick_i, cmp_i,
    output count_o, running_o, match_o, done_o
  );
endinterface

// File: rtl/timer_unit_counter.sv
// timer_unit_counter: counter stage fed by the prescaler tick. It counts
// ticks in RUN and pulses match_o when the count equals the compare value.
// On a match it either reloads to zero (continuous) or stops in DONE
// (one-shot). One-shot support exists only when TIMER_UNIT_COUNTER_ONESHOT_EN
// is defined; otherwise the counter is always continuous and done_o is 0.
// Same-cycle priority: rst_i > clear_i > stop_i > start_i > tick_i.
module timer_unit_counter #(
  parameter int WIDTH = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  timer_unit_counter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             match_q;
  logic             running_q;
  logic             hit;
  logic             oneshot_mode;

`ifdef TIMER_UNIT_COUNTER_ONESHOT_EN
  logic mode_q;
  logic done_q;
  assign oneshot_mode = mode_q;
  assign bus.done_o   = done_q;
`else
  logic unused_oneshot;
  assign unused_oneshot = bus.oneshot_i;
  assign oneshot_mode   = 1'b0;
  assign bus.done_o     = 1'b0;
`endif

  assign bus.count_o   = count_q;
  assign bus.running_o = running_q;
  assign bus.match_o   = match_q;

  // Compare against the live compare value and precompute the increment.
  always_comb begin
    hit     = (count_q == bus.cmp_i);
    count_d = count_q + WIDTH'(1);
  end

  // Single FSM block: state, count and all status outputs are registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      count_q   <= '0;
      match_q   <= 1'b0;
      running_q <= 1'b0;
`ifdef TIMER_UNIT_COUNTER_ONESHOT_EN
      mode_q    <= 1'b0;
      done_q    <= 1'b0;
`endif
    end else begin
      match_q <= 1'b0;
      if (bus.clear_i) begin
        count_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start_i && !bus.stop_i) begin
              state_q   <= RUN;
              running_q <= 1'b1;
`ifdef TIMER_UNIT_COUNTER_ONESHOT_EN
              mode_q    <= bus.oneshot_i;
`endif
            end
          end
          RUN: begin
            if (bus.stop_i) begin
              state_q   <= IDLE;
              running_q <= 1'b0;
            end else if (bus.tick_i) begin
              if (hit) begin
                count_q <= '0;
                match_q <= 1'b1;
                if (oneshot_mode) begin
                  state_q   <= DONE;
                  running_q <= 1'b0;
`ifdef TIMER_UNIT_COUNTER_ONESHOT_EN
                  done_q    <= 1'b1;
`endif
                end
              end else begin
                count_q <= count_d;
              end
            end
          end
          DONE: begin
            if (bus.stop_i) begin
              state_q <= IDLE;
`ifdef TIMER_UNIT_COUNTER_ONESHOT_EN
              done_q  <= 1'b0;
`endif
            end else if (bus.start_i) begin
              state_q   <= RUN;
              running_q <= 1'b1;
`ifdef TIMER_UNIT_COUNTER_ONESHOT_EN
              done_q    <= 1'b0;
              mode_q    <= bus.oneshot_i;
`endif
            end
          end
          default: begin
            state_q   <= IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_unit_counter.sv
// tb_timer_unit_counter: drives a 32-bit and an 8-bit counter with the same
// control stimulus. A behavioural model predicts each cycle's outputs, which
// are queued when stimulus is applied and compared after the clock edge.
module tb_timer_unit_counter;

`ifdef TIMER_UNIT_COUNTER_ONESHOT_EN
  localparam bit OS_EN = 1'b1;
`else
  localparam bit OS_EN = 1'b0;
`endif
  localparam logic [63:0] MASK32 = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] MASK8  = 64'h0000_0000_0000_00FF;

  typedef struct {
    int          st;
    logic [63:0] cnt;
    logic        mode;
    logic        match;
  } mdlT;

  typedef struct {
    logic [63:0] cnt;
    logic        run;
    logic        match;
    logic        done;
  } expT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   assertCount = 0;
  int   failCount = 0;
  int   match32 = 0;
  int   match8 = 0;
  mdlT  m32;
  mdlT  m8;
  expT  q32[$];
  expT  q8[$];

  timer_unit_counter_if #(.WIDTH(32)) if32 ();
  timer_unit_counter_if #(.WIDTH(8))  if8 ();

  timer_unit_counter #(.WIDTH(32)) dut32 (.clk_i(clk), .rst_i(rst), .bus(if32));
  timer_unit_counter #(.WIDTH(8))  dut8  (.clk_i(clk), .rst_i(rst), .bus(if8));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of one clock edge, independent of the DUT structure.
  function automatic mdlT stepModel(input mdlT m, input logic st, input logic sp,
                                    input logic cl, input logic os,
                                    input logic [63:0] cmp, input logic tk,
                                    input logic [63:0] mask);
    mdlT n;
    n = m;
    n.match = 1'b0;
    if (cl) begin
      n.cnt = '0;
    end else if (sp) begin
      n.st = 0;
    end else if (st && m.st != 1) begin
      n.st   = 1;
      n.mode = OS_EN ? os : 1'b0;
    end else if (tk && m.st == 1) begin
      if (m.cnt == (cmp & mask)) begin
        n.cnt   = '0;
        n.match = 1'b1;
        if (n.mode) n.st = 2;
      end else begin
        n.cnt = (m.cnt + 64'd1) & mask;
      end
    end
    return n;
  endfunction

  function automatic expT toExp(input mdlT m);
    expT e;
    e.cnt   = m.cnt;
    e.run   = (m.st == 1);
    e.match = m.match;
    e.done  = (m.st == 2);
    return e;
  endfunction

  function automatic mdlT resetModel();
    mdlT m;
    m.st = 0;
    m.cnt = '0;
    m.mode = 1'b0;
    m.match = 1'b0;
    return m;
  endfunction

  task automatic applyStimulus(input logic st, input logic sp, input logic cl,
                               input logic os, input logic [63:0] cmp, input logic tk);
    expT e;
    @(negedge clk);
    if32.start_i = st;  if8.start_i = st;
    if32.stop_i = sp;   if8.stop_i = sp;
    if32.clear_i = cl;  if8.clear_i = cl;
    if32.oneshot_i = os; if8.oneshot_i = os;
    if32.tick_i = tk;   if8.tick_i = tk;
    if32.cmp_i = cmp[31:0];
    if8.cmp_i = cmp[7:0];
    m32 = stepModel(m32, st, sp, cl, os, cmp, tk, MASK32);
    m8  = stepModel(m8, st, sp, cl, os, cmp, tk, MASK8);
    q32.push_back(toExp(m32));
    q8.push_back(toExp(m8));
    @(posedge clk);
    #1;
    e = q32.pop_front();
    checkOutput("count32", if32.count_o, e.cnt);
    checkOutput("running32", 64'(if32.running_o), 64'(e.run));
    checkOutput("match32", 64'(if32.match_o), 64'(e.match));
    checkOutput("done32", 64'(if32.done_o), 64'(e.done));
    e = q8.pop_front();
    checkOutput("count8", 64'(if8.count_o), e.cnt);
    checkOutput("running8", 64'(if8.running_o), 64'(e.run));
    checkOutput("match8", 64'(if8.match_o), 64'(e.match));
    checkOutput("done8", 64'(if8.done_o), 64'(e.done));
    if (if32.match_o) match32++;
    if (if8.match_o) match8++;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_count32"}, if32.count_o, 64'd0);
    checkOutput({tag, "_run32"}, 64'(if32.running_o), 64'd0);
    checkOutput({tag, "_match32"}, 64'(if32.match_o), 64'd0);
    checkOutput({tag, "_done32"}, 64'(if32.done_o), 64'd0);
    checkOutput({tag, "_count8"}, 64'(if8.count_o), 64'd0);
    checkOutput({tag, "_run8"}, 64'(if8.running_o), 64'd0);
  endtask

  initial begin
    if32.start_i = 0; if32.stop_i = 0; if32.clear_i = 0; if32.oneshot_i = 0;
    if32.tick_i = 0;  if32.cmp_i = '0;
    if8.start_i = 0;  if8.stop_i = 0;  if8.clear_i = 0;  if8.oneshot_i = 0;
    if8.tick_i = 0;   if8.cmp_i = '0;
    m32 = resetModel();
    m8  = resetModel();

    // Reset state
    #1 rst = 1'b1;
    #2 checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Continuous mode, cmp = 3, one tick every 4 cycles
    applyStimulus(1, 0, 0, 0, 64'd3, 0);
    match32 = 0;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(0, 0, 0, 0, 64'd3, 1);
      checkOutput("contCount", if32.count_o, 64'(k % 4));
      checkOutput("contRun", 64'(if32.running_o), 64'd1);
      for (int j = 0; j < 3; j++) applyStimulus(0, 0, 0, 0, 64'd3, 0);
    end
    checkOutput("contMatches", 64'(match32), 64'd3);
    applyStimulus(0, 1, 0, 0, 64'd3, 0);
    applyStimulus(0, 0, 1, 0, 64'd3, 0);

`ifdef TIMER_UNIT_COUNTER_ONESHOT_EN
    // One-shot, cmp = 5, continuous ticks
    applyStimulus(1, 0, 0, 1, 64'd5, 0);
    match32 = 0;
    for (int k = 0; k < 6; k++) applyStimulus(0, 0, 0, 1, 64'd5, 1);
    checkOutput("osCount", if32.count_o, 64'd0);
    checkOutput("osDone", 64'(if32.done_o), 64'd1);
    checkOutput("osRun", 64'(if32.running_o), 64'd0);
    checkOutput("osMatches", 64'(match32), 64'd1);
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 0, 64'd5, 1);
    checkOutput("osHeld", if32.count_o, 64'd0);
    checkOutput("osMatchesAfter", 64'(match32), 64'd1);
    applyStimulus(0, 1, 0, 0, 64'd5, 0);
`else
    // Macro undefined: oneshot_i ignored, counter keeps cycling
    applyStimulus(1, 0, 0, 1, 64'd2, 0);
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(0, 0, 0, 1, 64'd2, 1);
      checkOutput("noOsCount", if32.count_o, 64'(k % 3));
      checkOutput("noOsDone", 64'(if32.done_o), 64'd0);
    end
    applyStimulus(0, 1, 0, 0, 64'd2, 0);
`endif

    // Collision: clear with a matching tick
    applyStimulus(0, 0, 1, 0, 64'd100, 0);
    applyStimulus(1, 0, 0, 0, 64'd100, 0);
    for (int k = 0; k < 7; k++) applyStimulus(0, 0, 0, 0, 64'd100, 1);
    checkOutput("preClear", if32.count_o, 64'd7);
    applyStimulus(0, 0, 1, 0, 64'd7, 1);
    checkOutput("clrCount", if32.count_o, 64'd0);
    checkOutput("clrMatch", 64'(if32.match_o), 64'd0);
    checkOutput("clrRun", 64'(if32.running_o), 64'd1);

    // Collision: stop with a matching tick
    for (int k = 0; k < 7; k++) applyStimulus(0, 0, 0, 0, 64'd100, 1);
    applyStimulus(0, 1, 0, 0, 64'd7, 1);
    checkOutput("stopCount", if32.count_o, 64'd7);
    checkOutput("stopMatch", 64'(if32.match_o), 64'd0);
    checkOutput("stopRun", 64'(if32.running_o), 64'd0);

    // cmp = 0: match on every tick
    applyStimulus(0, 0, 1, 0, 64'd0, 0);
    applyStimulus(1, 0, 0, 0, 64'd0, 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 0, 0, 64'd0, 1);
      checkOutput("cmp0Match", 64'(if32.match_o), 64'd1);
      checkOutput("cmp0Count", if32.count_o, 64'd0);
    end
    applyStimulus(0, 1, 0, 0, 64'd0, 0);

    // Lower compare below count on the 8-bit counter: wrap without match
    applyStimulus(0, 0, 1, 0, 64'd100, 0);
    applyStimulus(1, 0, 0, 0, 64'd100, 0);
    for (int k = 0; k < 50; k++) applyStimulus(0, 0, 0, 0, 64'd100, 1);
    checkOutput("wrapStart", 64'(if8.count_o), 64'd50);
    match8 = 0;
    for (int k = 0; k < 206; k++) applyStimulus(0, 0, 0, 0, 64'd10, 1);
    checkOutput("wrapCount", 64'(if8.count_o), 64'd0);
    checkOutput("wrapNoMatch", 64'(match8), 64'd0);
    for (int k = 0; k < 10; k++) applyStimulus(0, 0, 0, 0, 64'd10, 1);
    checkOutput("wrapAt10", 64'(if8.count_o), 64'd10);
    applyStimulus(0, 0, 0, 0, 64'd10, 1);
    checkOutput("wrapMatch", 64'(if8.match_o), 64'd1);
    checkOutput("wrapMatchCount", 64'(if8.count_o), 64'd0);
    applyStimulus(0, 1, 0, 0, 64'd10, 0);

    // Async reset in the middle of a run
    applyStimulus(0, 0, 1, 0, 64'hFFFF_FFFF, 0);
    applyStimulus(1, 0, 0, 0, 64'hFFFF_FFFF, 0);
    for (int k = 0; k < 32'h1234; k++) applyStimulus(0, 0, 0, 0, 64'hFFFF_FFFF, 1);
    checkOutput("preReset", if32.count_o, 64'h1234);
    #2 rst = 1'b1;
    #1 checkAllZero("asyncRst");
    @(negedge clk);
    rst = 1'b0;
    m32 = resetModel();
    m8  = resetModel();
    applyStimulus(0, 0, 0, 0, 64'hFFFF_FFFF, 1);
    checkOutput("idleAfterRst", if32.count_o, 64'd0);
    applyStimulus(1, 0, 0, 0, 64'hFFFF_FFFF, 0);
    applyStimulus(0, 0, 0, 0, 64'hFFFF_FFFF, 1);
    checkOutput("resume", if32.count_o, 64'd1);
    checkOutput("resumeRun", 64'(if32.running_o), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
